cpu_control: RTL and testbench
==============================

Name: cpu_control

Overview:
Multi-cycle sequencer for the 16-bit core. It fetches instructions over a req/ack memory port, decodes them, and drives the ALU's dst/src/oper/func/cond/psrRead inputs. It owns PC, IR and the 5-bit PSR, and sequences register-file writeback and load/store. It sits between the unified memory, the register file (async read) and the alu module.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
DATA_W, 16, datapath width (fixed at 16; not to be overridden)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
halt  in  1  when high, controller idles in FETCH and issues no new request
mem_req  out  1  memory request, registered
mem_we  out  1  1 = write (STORE)
mem_addr  out  16  word address
mem_wdata  out  16  store data
mem_rdata  in  16  read data, valid when mem_ack=1
mem_ack  in  1  one-cycle acknowledge
rf_raddr_a  out  4  read port A = IR[11:8] (rdest)
rf_raddr_b  out  4  read port B = IR[3:0] (rsrc)
rf_rdata_a  in  16  async read data A
rf_rdata_b  in  16  async read data B
rf_we  out  1  register write strobe
rf_waddr  out  4  write address
rf_wdata  out  16  write data
alu_dst  out  16  ALU dst operand
alu_src  out  16  ALU src operand
alu_oper  out  4  IR[15:12]
alu_func  out  4  IR[7:4]
alu_cond  out  4  condition code (IR[11:8] for BCOND/JCOND/SCOND)
alu_psr_read  out  5  PSR {c,l,f,z,n}
alu_result  in  16  ALU result
alu_psr_write  in  5  new flag values
alu_psr_wren  in  5  per-flag write enables
pc  out  16  current PC
retire  out  1  one-cycle pulse per completed instruction
illegal  out  1  one-cycle pulse on undefined encoding (executed as NOP)

Behaviour:
- Reset: state=FETCH, PC=RESET_PC, IR=0, PSR=0. mem_req, mem_we, rf_we, retire and illegal are 0. mem_addr and mem_wdata are 0.
- States: FETCH -> DECODE -> EXECUTE -> {MEM | WRITEBACK | FETCH}. MEM -> WRITEBACK for LOAD, MEM -> FETCH for STORE. WRITEBACK -> FETCH.
- FETCH: mem_req rises the cycle after entering FETCH (if halt=0) with mem_addr=PC and mem_we=0. mem_ack counts only while mem_req=1. On ack: IR<=mem_rdata, PC<=PC+1 (wraps FFFF->0000), mem_req drops next cycle, go to DECODE.
- DECODE: latch A<=rf_rdata_a and B<=rf_rdata_b. Form IMM from IR[7:8-bit]:
  - ANDI, ORI, XORI, ADDUI, LUI: zero-extend.
  - Other immediates and BCOND displacement: sign-extend.
  - SHIFT: src={11'b0, IR[4:0]}.
- EXECUTE (one cycle):
  - Operands: alu_dst=A (PC for BCOND/JCOND/JAL). alu_src=B for REGISTER/SPECIAL, IMM otherwise.
  - Flags: for each i with alu_psr_wren[i]=1, PSR[i]<=alu_psr_write[i] at end of cycle.
  - Result latched into R.
  - BCOND/JCOND: PC<=R, then FETCH.
  - JAL: R_link=PC, PC<=alu_result.
- MEM: LOAD drives mem_addr=B, mem_we=0, and the result goes to R on ack. STORE drives mem_addr=B, mem_wdata=A, mem_we=1. Request rules match FETCH.
- WRITEBACK: rf_we=1 for one cycle, rf_waddr=IR[11:8], rf_wdata=R (R_link for JAL).
- No writeback for CMP, CMPI, TEST, STORE, BCOND, JCOND. These retire from EXECUTE or MEM.
- Latency (zero-wait memory): ALU op = 5 cycles, load = 7 cycles, branch = 4 cycles.
- retire: pulses on the cycle the state returns to FETCH.
- Undefined encodings (SPECIAL func not in {LOAD, STORE, JAL, JCOND, SCOND}; REGISTER func 0000/1000/1100; SHIFT func not in {0000, 0001, 0010, 0011, 0100, 0110}): illegal=1 in EXECUTE, no PSR/reg/PC change beyond the fetch increment.
- halt: sampled only in FETCH before mem_req rises. An outstanding request always completes.
- Reset mid-transaction: mem_req drops at that edge. An ack arriving while mem_req=0 is ignored.

Decomposition:
- Shared package cpu_defs: oper, func, cond and PSR bit-index constants. The ALU bench uses the same package.
- One sub-module, cpu_decode (combinational): IR -> imm_sel, src_sel, wb_en, mem_op, is_branch, illegal.

Test Plan:
- Reset, then ADDI r1,#5 at addr 0 with zero-wait memory -> rf_we at cycle 5, waddr=1, wdata=0x0005; PC=1; retire pulses once.
- PSR 0x00, CMPI r2(=3),#7 -> PSR.l=1, z=0, no rf_we; next BCOND LO +4 at PC=1 taken -> PC=0x0006.
- LOAD r3,[r4=0x0100] with mem_ack delayed 3 cycles -> mem_req held with addr 0x0100 for 4 cycles; r3=mem_rdata.
- PC=0xFFFF, NOP-class fetch -> PC wraps to 0x0000.
- SPECIAL func 0001 -> illegal pulse, no rf_we, PSR unchanged, retire pulses.
- reset asserted while mem_req=1 -> mem_req=0 next cycle, PC=RESET_PC, and a stray ack is ignored.

Source files
------------

// File: rtl/cpu_control_pkg.sv
// Shared encodings for the 16-bit core: opcodes, function codes, conditions,
// PSR bit positions and the decoder's control bundle.
package cpu_defs;

  localparam logic [3:0] OP_REG     = 4'b0000;
  localparam logic [3:0] OP_ANDI    = 4'b0001;
  localparam logic [3:0] OP_ORI     = 4'b0010;
  localparam logic [3:0] OP_XORI    = 4'b0011;
  localparam logic [3:0] OP_SPECIAL = 4'b0100;
  localparam logic [3:0] OP_ADDI    = 4'b0101;
  localparam logic [3:0] OP_ADDUI   = 4'b0110;
  localparam logic [3:0] OP_ADDCI   = 4'b0111;
  localparam logic [3:0] OP_SHIFT   = 4'b1000;
  localparam logic [3:0] OP_SUBI    = 4'b1001;
  localparam logic [3:0] OP_SUBCI   = 4'b1010;
  localparam logic [3:0] OP_CMPI    = 4'b1011;
  localparam logic [3:0] OP_BCOND   = 4'b1100;
  localparam logic [3:0] OP_MOVI    = 4'b1101;
  localparam logic [3:0] OP_MULI    = 4'b1110;
  localparam logic [3:0] OP_LUI     = 4'b1111;

  localparam logic [3:0] FN_CMP   = 4'b1011;
  localparam logic [3:0] FN_TEST  = 4'b1111;
  localparam logic [3:0] FN_LOAD  = 4'b0000;
  localparam logic [3:0] FN_STORE = 4'b0100;
  localparam logic [3:0] FN_JAL   = 4'b1000;
  localparam logic [3:0] FN_JCOND = 4'b1100;
  localparam logic [3:0] FN_SCOND = 4'b1101;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_LO = 4'b1010;
  localparam logic [3:0] COND_UC = 4'b1110;

  localparam int PSR_N = 0;
  localparam int PSR_Z = 1;
  localparam int PSR_F = 2;
  localparam int PSR_L = 3;
  localparam int PSR_C = 4;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITEBACK
  } state_t;

  typedef enum logic [1:0] {
    IMM_SEXT,
    IMM_ZEXT,
    IMM_SHIFT
  } imm_sel_t;

  typedef enum logic [1:0] {
    MEM_NONE,
    MEM_LOAD,
    MEM_STORE
  } mem_op_t;

  typedef struct packed {
    imm_sel_t imm_sel;
    logic     src_imm;
    logic     dst_pc;
    logic     wb_en;
    mem_op_t  mem_op;
    logic     is_branch;
    logic     is_jal;
    logic     uses_cond;
    logic     illegal;
  } dec_t;

  function automatic logic [15:0] form_imm(input logic [7:0] imm8, input imm_sel_t sel);
    case (sel)
      IMM_ZEXT:  return {8'h00, imm8};
      IMM_SHIFT: return {11'h000, imm8[4:0]};
      default:   return {{8{imm8[7]}}, imm8};
    endcase
  endfunction

endpackage

// File: rtl/cpu_control_decode.sv
// Combinational instruction classifier: opcode/function fields to control bundle.
module cpu_decode
  import cpu_defs::*;
(
  input  logic [3:0] oper_i,
  input  logic [3:0] func_i,
  output dec_t       dec_o
);

  // Classify the instruction; undefined encodings fall through to a NOP with illegal set.
  always_comb begin
    dec_o = '{imm_sel: IMM_SEXT, src_imm: 1'b1, dst_pc: 1'b0, wb_en: 1'b1,
              mem_op: MEM_NONE, is_branch: 1'b0, is_jal: 1'b0,
              uses_cond: 1'b0, illegal: 1'b0};
    case (oper_i)
      OP_REG: begin
        dec_o.src_imm = 1'b0;
        if (func_i == 4'b0000 || func_i == 4'b1000 || func_i == 4'b1100) begin
          dec_o.wb_en   = 1'b0;
          dec_o.illegal = 1'b1;
        end else begin
          dec_o.wb_en = (func_i != FN_CMP) && (func_i != FN_TEST);
        end
      end
      OP_SPECIAL: begin
        dec_o.src_imm = 1'b0;
        case (func_i)
          FN_LOAD:  dec_o.mem_op = MEM_LOAD;
          FN_STORE: begin
            dec_o.mem_op = MEM_STORE;
            dec_o.wb_en  = 1'b0;
          end
          FN_JAL: begin
            dec_o.is_jal = 1'b1;
            dec_o.dst_pc = 1'b1;
          end
          FN_JCOND: begin
            dec_o.is_branch = 1'b1;
            dec_o.dst_pc    = 1'b1;
            dec_o.uses_cond = 1'b1;
            dec_o.wb_en     = 1'b0;
          end
          FN_SCOND: dec_o.uses_cond = 1'b1;
          default: begin
            dec_o.wb_en   = 1'b0;
            dec_o.illegal = 1'b1;
          end
        endcase
      end
      OP_SHIFT: begin
        dec_o.imm_sel = IMM_SHIFT;
        case (func_i)
          4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0110: dec_o.wb_en = 1'b1;
          default: begin
            dec_o.wb_en   = 1'b0;
            dec_o.illegal = 1'b1;
          end
        endcase
      end
      OP_BCOND: begin
        dec_o.is_branch = 1'b1;
        dec_o.dst_pc    = 1'b1;
        dec_o.uses_cond = 1'b1;
        dec_o.wb_en     = 1'b0;
      end
      OP_CMPI: dec_o.wb_en = 1'b0;
      OP_ANDI, OP_ORI, OP_XORI, OP_ADDUI, OP_LUI: dec_o.imm_sel = IMM_ZEXT;
      default: dec_o.wb_en = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_control.sv
// Multi-cycle fetch/decode/execute sequencer owning PC, IR and PSR; drives the
// ALU operands, register-file writeback and the req/ack memory port.
module cpu_control
  import cpu_defs::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned DATA_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              halt,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [3:0]        rf_raddr_a,
  output logic [3:0]        rf_raddr_b,
  input  logic [DATA_W-1:0] rf_rdata_a,
  input  logic [DATA_W-1:0] rf_rdata_b,
  output logic              rf_we,
  output logic [3:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] alu_dst,
  output logic [DATA_W-1:0] alu_src,
  output logic [3:0]        alu_oper,
  output logic [3:0]        alu_func,
  output logic [3:0]        alu_cond,
  output logic [4:0]        alu_psr_read,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [4:0]        alu_psr_write,
  input  logic [4:0]        alu_psr_wren,
  output logic [DATA_W-1:0] pc,
  output logic              retire,
  output logic              illegal
);

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d, ir_q, ir_d;
  logic [4:0]  psr_q, psr_d;
  logic [15:0] a_q, a_d, b_q, b_d, imm_q, imm_d, r_q, r_d, link_q, link_d;
  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic        rf_we_q, rf_we_d, retire_q, retire_d, illegal_q, illegal_d;
  dec_t        dec;

  cpu_decode u_decode (
    .oper_i (ir_q[15:12]),
    .func_i (ir_q[7:4]),
    .dec_o  (dec)
  );

  // Next-state and datapath updates; an ack only counts while our request is up.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    psr_d       = psr_q;
    a_d         = a_q;
    b_d         = b_q;
    imm_d       = imm_q;
    r_d         = r_q;
    link_d      = link_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_FETCH: begin
        if (mem_req_q) begin
          if (mem_ack) begin
            ir_d      = mem_rdata;
            pc_d      = pc_q + 16'h0001;
            mem_req_d = 1'b0;
            state_d   = S_DECODE;
          end else begin
            mem_req_d = 1'b1;
          end
        end else if (!halt) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = pc_q;
        end else begin
          mem_req_d = 1'b0;
        end
      end
      S_DECODE: begin
        a_d     = rf_rdata_a;
        b_d     = rf_rdata_b;
        imm_d   = form_imm(ir_q[7:0], dec.imm_sel);
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (dec.illegal) begin
          state_d = S_FETCH;
        end else begin
          psr_d = (psr_q & ~alu_psr_wren) | (alu_psr_write & alu_psr_wren);
          r_d   = alu_result;
          if (dec.is_branch) begin
            pc_d    = alu_result;
            state_d = S_FETCH;
          end else if (dec.is_jal) begin
            link_d  = pc_q;
            pc_d    = alu_result;
            state_d = S_WRITEBACK;
          end else if (dec.mem_op != MEM_NONE) begin
            state_d = S_MEM;
          end else if (dec.wb_en) begin
            state_d = S_WRITEBACK;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_MEM: begin
        if (mem_req_q) begin
          if (mem_ack) begin
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
            if (dec.mem_op == MEM_LOAD) begin
              r_d     = mem_rdata;
              state_d = S_WRITEBACK;
            end else begin
              state_d = S_FETCH;
            end
          end else begin
            mem_req_d = 1'b1;
          end
        end else begin
          mem_req_d  = 1'b1;
          mem_we_d   = (dec.mem_op == MEM_STORE);
          mem_addr_d = b_q;
          if (dec.mem_op == MEM_STORE) begin
            mem_wdata_d = a_q;
          end else begin
            mem_wdata_d = mem_wdata_q;
          end
        end
      end
      S_WRITEBACK: state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
    rf_we_d   = (state_d == S_WRITEBACK);
    retire_d  = (state_d == S_FETCH) && (state_q != S_FETCH);
    illegal_d = (state_d == S_EXECUTE) && dec.illegal;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= 16'h0000;
      psr_q       <= 5'b00000;
      a_q         <= 16'h0000;
      b_q         <= 16'h0000;
      imm_q       <= 16'h0000;
      r_q         <= 16'h0000;
      link_q      <= 16'h0000;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 16'h0000;
      rf_we_q     <= 1'b0;
      retire_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      psr_q       <= psr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      imm_q       <= imm_d;
      r_q         <= r_d;
      link_q      <= link_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rf_we_q     <= rf_we_d;
      retire_q    <= retire_d;
      illegal_q   <= illegal_d;
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign rf_raddr_a   = ir_q[11:8];
  assign rf_raddr_b   = ir_q[3:0];
  assign rf_we        = rf_we_q;
  assign rf_waddr     = ir_q[11:8];
  assign rf_wdata     = dec.is_jal ? link_q : r_q;
  assign alu_dst      = dec.dst_pc ? pc_q : a_q;
  assign alu_src      = dec.src_imm ? imm_q : b_q;
  assign alu_oper     = ir_q[15:12];
  assign alu_func     = ir_q[7:4];
  assign alu_cond     = dec.uses_cond ? ir_q[11:8] : 4'h0;
  assign alu_psr_read = psr_q;
  assign pc           = pc_q;
  assign retire       = retire_q;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_cpu_control.sv
// Directed bench for cpu_control with a zero/N-wait memory, register file and ALU model.
module tb_cpu_control;
  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        reset, halt;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [15:0] rf_rdata_a, rf_rdata_b, rf_wdata;
  logic        rf_we;
  logic [15:0] alu_dst, alu_src, alu_result, pc;
  logic [3:0]  alu_oper, alu_func, alu_cond;
  logic [4:0]  alu_psr_read, alu_psr_write, alu_psr_wren;
  logic        retire, illegal;

  logic [15:0] mem [0:65535];
  logic [15:0] rf  [0:15];
  int          ack_wait = 0;
  int          req_cnt  = 0;
  logic        ack_force = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  cpu_control #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .halt(halt),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_dst(alu_dst), .alu_src(alu_src), .alu_oper(alu_oper), .alu_func(alu_func),
    .alu_cond(alu_cond), .alu_psr_read(alu_psr_read), .alu_result(alu_result),
    .alu_psr_write(alu_psr_write), .alu_psr_wren(alu_psr_wren),
    .pc(pc), .retire(retire), .illegal(illegal)
  );

  assign mem_ack    = ack_force | (mem_req && (req_cnt == ack_wait));
  assign mem_rdata  = mem[mem_addr];
  assign rf_rdata_a = rf[rf_raddr_a];
  assign rf_rdata_b = rf[rf_raddr_b];

  always @(posedge clk) begin
    if (mem_req && !mem_ack) req_cnt <= req_cnt + 1;
    else                     req_cnt <= 0;
  end

  // Reference ALU: compares set l/z/n, BCOND LO follows PSR.l, JCOND jumps to src,
  // SPECIAL func 0001 tries to clobber every flag.
  always_comb begin
    alu_result    = alu_dst + alu_src;
    alu_psr_wren  = 5'b00000;
    alu_psr_write = 5'b00000;
    if (alu_oper == OP_CMPI || (alu_oper == OP_REG && alu_func == FN_CMP)) begin
      alu_psr_wren  = 5'b01011;
      alu_psr_write = {1'b0, alu_dst < alu_src, 1'b0, alu_dst == alu_src,
                       $signed(alu_dst) < $signed(alu_src)};
    end else if (alu_oper == OP_BCOND) begin
      if ((alu_cond == COND_LO && alu_psr_read[PSR_L]) || alu_cond == COND_UC)
        alu_result = alu_dst + alu_src;
      else
        alu_result = alu_dst;
    end else if (alu_oper == OP_SPECIAL && alu_func == FN_JCOND) begin
      alu_result = alu_src;
    end else if (alu_oper == OP_SPECIAL && alu_func == 4'b0001) begin
      alu_psr_wren  = 5'b11111;
      alu_psr_write = 5'b10101;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    halt  = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 16; i++) rf[i] = 16'h0000;

    // ADDI r1,#5 with zero-wait memory
    mem[0] = 16'h5105;
    do_reset();
    check("rst_pc", pc, 16'h0000);
    check("rst_req", {15'h0, mem_req}, 16'h0);
    check("rst_we", {15'h0, mem_we}, 16'h0);
    check("rst_addr", mem_addr, 16'h0000);
    check("rst_wdata", mem_wdata, 16'h0000);
    check("rst_rfwe", {15'h0, rf_we}, 16'h0);
    check("rst_retire", {15'h0, retire}, 16'h0);
    check("rst_illegal", {15'h0, illegal}, 16'h0);
    check("rst_psr", {11'h0, alu_psr_read}, 16'h0000);
    tick();
    check("f_req", {15'h0, mem_req}, 16'h1);
    check("f_addr", mem_addr, 16'h0000);
    tick(); tick();
    check("addi_src", alu_src, 16'h0005);
    check("addi_dst", alu_dst, 16'h0000);
    tick();
    check("addi_rfwe", {15'h0, rf_we}, 16'h1);
    check("addi_waddr", {12'h0, rf_waddr}, 16'h0001);
    check("addi_wdata", rf_wdata, 16'h0005);
    check("addi_pc", pc, 16'h0001);
    check("addi_ret_early", {15'h0, retire}, 16'h0);
    tick();
    check("addi_retire", {15'h0, retire}, 16'h1);
    check("addi_rfwe_off", {15'h0, rf_we}, 16'h0);
    tick();
    check("addi_retire_once", {15'h0, retire}, 16'h0);

    // CMPI r2(=3),#7 then BCOND LO +4
    mem[0] = 16'hB207;
    mem[1] = 16'hCA04;
    rf[2]  = 16'h0003;
    do_reset();
    tick(); tick(); tick();
    check("cmpi_dst", alu_dst, 16'h0003);
    check("cmpi_src", alu_src, 16'h0007);
    tick();
    check("cmpi_psr", {11'h0, alu_psr_read}, 16'h0009);
    check("cmpi_rfwe", {15'h0, rf_we}, 16'h0);
    check("cmpi_retire", {15'h0, retire}, 16'h1);
    check("cmpi_pc", pc, 16'h0001);
    tick(); tick(); tick();
    check("bc_dst", alu_dst, 16'h0002);
    check("bc_src", alu_src, 16'h0004);
    check("bc_cond", {12'h0, alu_cond}, 16'h000A);
    tick();
    check("bc_pc", pc, 16'h0006);
    check("bc_retire", {15'h0, retire}, 16'h1);
    check("bc_rfwe", {15'h0, rf_we}, 16'h0);

    // LOAD r3,[r4=0x0100] with a 3-cycle ack delay
    mem[0]       = 16'h4304;
    rf[4]        = 16'h0100;
    mem[16'h0100] = 16'hBEEF;
    do_reset();
    tick(); tick(); tick();
    ack_wait = 3;
    tick();
    check("ld_req_idle", {15'h0, mem_req}, 16'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("ld_req_held", {15'h0, mem_req}, 16'h1);
      check("ld_addr", mem_addr, 16'h0100);
      check("ld_we", {15'h0, mem_we}, 16'h0);
    end
    tick();
    ack_wait = 0;
    check("ld_req_drop", {15'h0, mem_req}, 16'h0);
    check("ld_rfwe", {15'h0, rf_we}, 16'h1);
    check("ld_waddr", {12'h0, rf_waddr}, 16'h0003);
    check("ld_wdata", rf_wdata, 16'hBEEF);
    tick();
    check("ld_retire", {15'h0, retire}, 16'h1);

    // JCOND UC to 0xFFFF, then fetch of 0x0000 wraps PC
    mem[0] = 16'h4EC5;
    rf[5]  = 16'hFFFF;
    do_reset();
    tick(); tick(); tick();
    check("jc_dst", alu_dst, 16'h0001);
    check("jc_src", alu_src, 16'hFFFF);
    check("jc_cond", {12'h0, alu_cond}, 16'h000E);
    tick();
    check("jc_pc", pc, 16'hFFFF);
    tick();
    check("wrap_addr", mem_addr, 16'hFFFF);
    tick();
    check("wrap_pc", pc, 16'h0000);
    tick();
    check("nop_illegal", {15'h0, illegal}, 16'h1);
    tick();
    check("nop_illegal_off", {15'h0, illegal}, 16'h0);
    check("nop_pc", pc, 16'h0000);
    check("nop_retire", {15'h0, retire}, 16'h1);

    // Undefined SPECIAL func 0001 after CMPI sets PSR
    mem[0] = 16'hB207;
    mem[1] = 16'h4110;
    do_reset();
    tick(); tick(); tick(); tick();
    check("ill_psr_before", {11'h0, alu_psr_read}, 16'h0009);
    tick(); tick(); tick();
    check("ill_pulse", {15'h0, illegal}, 16'h1);
    check("ill_rfwe_ex", {15'h0, rf_we}, 16'h0);
    tick();
    check("ill_pulse_off", {15'h0, illegal}, 16'h0);
    check("ill_psr_kept", {11'h0, alu_psr_read}, 16'h0009);
    check("ill_pc", pc, 16'h0002);
    check("ill_retire", {15'h0, retire}, 16'h1);
    check("ill_rfwe", {15'h0, rf_we}, 16'h0);

    // Reset while a fetch is outstanding, then a stray ack
    ack_wait = 5;
    do_reset();
    tick();
    check("mid_req", {15'h0, mem_req}, 16'h1);
    tick();
    check("mid_req_held", {15'h0, mem_req}, 16'h1);
    reset = 1'b1;
    tick();
    check("mid_req_drop", {15'h0, mem_req}, 16'h0);
    check("mid_pc", pc, 16'h0000);
    reset     = 1'b0;
    ack_force = 1'b1;
    tick();
    ack_force = 1'b0;
    check("stray_req", {15'h0, mem_req}, 16'h1);
    check("stray_pc", pc, 16'h0000);
    ack_wait = 0;
    tick();
    check("after_stray_pc", pc, 16'h0001);

    // halt holds off the fetch request
    halt = 1'b1;
    do_reset();
    tick(); tick();
    check("halt_noreq", {15'h0, mem_req}, 16'h0);
    halt = 1'b0;
    tick();
    check("unhalt_req", {15'h0, mem_req}, 16'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
